// File: rtl/bus_arbiter2.sv
// Two-master, one-slave round-robin arbiter for the valid/ready memory bus.
// Ownership is held until completion; a watchdog aborts transfers to a silent slave.
module bus_arbiter2 #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              TW       = 8,
  parameter int              TIMEOUT  = 255,
  parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [AW-1:0] m0_addr,
  input  logic [2:0]    m0_size,
  input  logic          m0_write,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_valid,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  input  logic [AW-1:0] m1_addr,
  input  logic [2:0]    m1_size,
  input  logic          m1_write,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_valid,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] s_addr,
  output logic [2:0]    s_size,
  output logic          s_write,
  output logic [DW-1:0] s_wdata,
  output logic          s_valid,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ready,
  output logic          err,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;

  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;

  logic          sel_m1;
  logic          req_valid;
  logic          to_hit;
  logic          done;
  logic [DW-1:0] rdata_mux;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      last  <= 1'b1;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    tcnt_nxt  = tcnt;
    sel_m1    = (state == G1);
    req_valid = 1'b0;
    to_hit    = 1'b0;
    done      = 1'b0;
    rdata_mux = '0;
    s_addr    = '0;
    s_size    = '0;
    s_write   = 1'b0;
    s_wdata   = '0;
    s_valid   = 1'b0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    err       = 1'b0;
    owner     = {state == G1, state == G0};

    case (state)
      IDLE: begin
        tcnt_nxt = '0;
        if (m0_valid && m1_valid) state_nxt = last ? G0 : G1;
        else if (m0_valid)        state_nxt = G0;
        else if (m1_valid)        state_nxt = G1;
      end
      G0, G1: begin
        req_valid = sel_m1 ? m1_valid : m0_valid;
        s_addr    = sel_m1 ? m1_addr  : m0_addr;
        s_size    = sel_m1 ? m1_size  : m0_size;
        s_write   = sel_m1 ? m1_write : m0_write;
        s_wdata   = sel_m1 ? m1_wdata : m0_wdata;
        // A master that has withdrawn its request is never reported as timed out.
        to_hit    = (TIMEOUT != 0) && req_valid && !s_ready && (tcnt == TO_LAST);
        s_valid   = req_valid && !to_hit;
        done      = (s_valid && s_ready) || to_hit;
        rdata_mux = to_hit ? ERR_DATA : s_rdata;
        err       = to_hit;
        if (sel_m1) begin
          m1_ready = done;
          m1_rdata = rdata_mux;
        end else begin
          m0_ready = done;
          m0_rdata = rdata_mux;
        end
        if (!req_valid) begin
          state_nxt = IDLE;
          tcnt_nxt  = '0;
        end else if (done) begin
          state_nxt = IDLE;
          last_nxt  = sel_m1;
          tcnt_nxt  = '0;
        end else if (tcnt != '1) begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Randomized bench for bus_arbiter2 against a transaction-level reference model.
module tb_bus_arbiter2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  localparam int NCYC = 2000;

  logic          clk = 1'b0;
  logic          rstb;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [2:0]    m0_size, m1_size, s_size;
  logic          m0_write, m1_write, s_write;
  logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
  logic          m0_valid, m1_valid, s_valid;
  logic          m0_ready, m1_ready, s_ready;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic          err;
  logic [1:0]    owner;

  bus_arbiter2 #(.AW(AW), .DW(DW), .TW(8), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rstb(rstb),
    .m0_addr(m0_addr), .m0_size(m0_size), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_size(m1_size), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_size(s_size), .s_write(s_write), .s_wdata(s_wdata),
    .s_valid(s_valid), .s_rdata(s_rdata), .s_ready(s_ready),
    .err(err), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, obs, exp);
  endtask

  // Reference model: who owns the bus (0 none, 1 m0, 2 m1), who was served last,
  // and how many granted cycles have elapsed without a slave answer.
  int own_m  = 0;
  int last_m = 1;
  int waited = 0;
  int own_nx, last_nx, waited_nx;

  logic          e_ready0, e_ready1, e_err, e_svalid, e_swrite;
  logic [DW-1:0] e_rdata0, e_rdata1, e_swdata;
  logic [AW-1:0] e_saddr;
  logic [2:0]    e_ssize;

  bit pend0 = 0, pend1 = 0;

  task automatic new_req(input int m);
    if (m == 0) begin
      m0_addr = $urandom; m0_size = 3'($urandom_range(0, 2));
      m0_write = 1'($urandom); m0_wdata = $urandom; pend0 = 1;
    end else begin
      m1_addr = $urandom; m1_size = 3'($urandom_range(0, 2));
      m1_write = 1'($urandom); m1_wdata = $urandom; pend1 = 1;
    end
  endtask

  task automatic model_eval();
    bit v, tout;
    e_ready0 = 0; e_ready1 = 0; e_err = 0; e_svalid = 0; e_swrite = 0;
    e_rdata0 = '0; e_rdata1 = '0; e_swdata = '0; e_saddr = '0; e_ssize = '0;
    own_nx = own_m; last_nx = last_m; waited_nx = waited;
    if (own_m == 0) begin
      waited_nx = 0;
      if (m0_valid && m1_valid) own_nx = (last_m == 1) ? 1 : 2;
      else if (m0_valid)        own_nx = 1;
      else if (m1_valid)        own_nx = 2;
    end else begin
      v = (own_m == 1) ? m0_valid : m1_valid;
      e_saddr  = (own_m == 1) ? m0_addr  : m1_addr;
      e_ssize  = (own_m == 1) ? m0_size  : m1_size;
      e_swrite = (own_m == 1) ? m0_write : m1_write;
      e_swdata = (own_m == 1) ? m0_wdata : m1_wdata;
      // The TO-th granted cycle without an answer is the abort cycle.
      tout = v && !s_ready && (waited + 1 == TO);
      e_svalid = v && !tout;
      e_err = tout;
      if (own_m == 1) begin
        e_ready0 = (v && s_ready) || tout;
        e_rdata0 = tout ? ERR : s_rdata;
      end else begin
        e_ready1 = (v && s_ready) || tout;
        e_rdata1 = tout ? ERR : s_rdata;
      end
      if (!v) begin
        own_nx = 0;
      end else if (s_ready || tout) begin
        own_nx = 0; last_nx = own_m - 1;
      end else begin
        waited_nx = waited + 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("owner",    64'(owner),    64'(own_m));
    chk("s_valid",  64'(s_valid),  64'(e_svalid));
    chk("s_addr",   64'(s_addr),   64'(e_saddr));
    chk("s_size",   64'(s_size),   64'(e_ssize));
    chk("s_write",  64'(s_write),  64'(e_swrite));
    chk("s_wdata",  64'(s_wdata),  64'(e_swdata));
    chk("m0_ready", 64'(m0_ready), 64'(e_ready0));
    chk("m0_rdata", 64'(m0_rdata), 64'(e_rdata0));
    chk("m1_ready", 64'(m1_ready), 64'(e_ready1));
    chk("m1_rdata", 64'(m1_rdata), 64'(e_rdata1));
    chk("err",      64'(err),      64'(e_err));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_owner"},  64'(owner),    64'd0);
    chk({tag, "_svalid"}, 64'(s_valid),  64'd0);
    chk({tag, "_saddr"},  64'(s_addr),   64'd0);
    chk({tag, "_swdata"}, 64'(s_wdata),  64'd0);
    chk({tag, "_ready0"}, 64'(m0_ready), 64'd0);
    chk({tag, "_ready1"}, 64'(m1_ready), 64'd0);
    chk({tag, "_rdata0"}, 64'(m0_rdata), 64'd0);
    chk({tag, "_rdata1"}, 64'(m1_rdata), 64'd0);
    chk({tag, "_err"},    64'(err),      64'd0);
  endtask

  initial begin
    rstb = 1'b0;
    m0_addr = '0; m0_size = '0; m0_write = 0; m0_wdata = '0; m0_valid = 0;
    m1_addr = '0; m1_size = '0; m1_write = 0; m1_wdata = '0; m1_valid = 0;
    s_rdata = '0; s_ready = 0;
    repeat (2) @(negedge clk);
    s_ready = 1; s_rdata = 32'h12345678; m0_valid = 1; m1_valid = 1;
    #1 check_all_zero("reset");
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    rstb = 1'b1;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // Mid-grant reset: outputs must drop at once, and the next tie goes to m0.
      if (cyc == 700 || cyc == 1400) begin
        if (own_m == 0) begin
          new_req(0); m0_valid = 1;
          @(posedge clk); @(negedge clk);
        end
        rstb = 1'b0;
        #1 check_all_zero("midrst");
        @(posedge clk); @(negedge clk);
        rstb = 1'b1;
        own_m = 0; last_m = 1; waited = 0;
        new_req(0); new_req(1);
      end
      if (!pend0 && ($urandom_range(0, 2) == 0)) new_req(0);
      else if (pend0 && ($urandom_range(0, 79) == 0)) pend0 = 0;
      if (!pend1 && ($urandom_range(0, 2) == 0)) new_req(1);
      else if (pend1 && ($urandom_range(0, 79) == 0)) pend1 = 0;
      m0_valid = pend0;
      m1_valid = pend1;
      // Stretches of a dead slave force watchdog aborts.
      if ((cyc % 300) >= 260) s_ready = 1'b0;
      else                    s_ready = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      #1;
      model_eval();
      check_outputs();
      if (e_ready0) pend0 = 0;
      if (e_ready1) pend1 = 0;
      @(posedge clk);
      own_m = own_nx; last_m = last_nx; waited = waited_nx;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
